// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between requesters, the shared UART transmitter and the arbiter.
// The arbiter connects through the slave modport; client/transmitter side uses master.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32
);
    logic [NUM_REQ-1:0]        Req;
    logic [NUM_REQ*DATA_W-1:0] Req_Data;
    logic                      Tx_busy;
    logic [NUM_REQ-1:0]        Grant;
    logic [DATA_W-1:0]         Data_Out;
    logic                      Tx_start;
    logic [NUM_REQ-1:0]        Ack;
    logic [NUM_REQ-1:0]        Err;
    logic                      Busy;

    modport master (
        output Req, Req_Data, Tx_busy,
        input  Grant, Data_Out, Tx_start, Ack, Err, Busy
    );

    modport slave (
        input  Req, Req_Data, Tx_busy,
        output Grant, Data_Out, Tx_start, Ack, Err, Busy
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ requesters.
// Runs entirely on the system clock; Tx_busy is the only view of the baud-domain frame.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | no owner; arbitrate when a request is pending and Tx_busy=0
// START     | one-cycle Tx_start strobe to the transmitter
// WAIT_BUSY | waiting for Tx_busy to rise; down-counter enforces timeout
// WAIT_DONE | frame in flight; waiting for Tx_busy to fall
// GAP       | enforced idle spacing before the next arbitration
module uart_tx_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int DATA_W        = 32,
    parameter int START_TIMEOUT = 16,
    parameter int GAP_CYCLES    = 2
) (
    input  logic               Clock_In,
    input  logic               Reset,
    uart_tx_arbiter_if.slave   bus
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TW = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT + 1) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_BUSY,
        WAIT_DONE,
        GAP
    } state_t;

    state_t              state;
    logic [IW-1:0]       ptr;
    logic [IW-1:0]       win;
    logic [IW-1:0]       cand;
    logic                win_vld;
    logic [TW-1:0]       tmo_cnt;
    logic [GW-1:0]       gap_cnt;
    logic [NUM_REQ-1:0]  grant;
    logic [NUM_REQ-1:0]  ack;
    logic [NUM_REQ-1:0]  err;
    logic [DATA_W-1:0]   data_out;
    logic                tx_start;
    logic                busy;

    // Scan from farthest to nearest so the requester closest after ptr wins.
    always_comb begin
        win     = ptr;
        cand    = ptr;
        win_vld = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = IW'((int'(ptr) + k) % NUM_REQ);
            if (bus.Req[cand]) begin
                win     = cand;
                win_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge Clock_In or negedge Reset) begin
        if (!Reset) begin
            state    <= IDLE;
            ptr      <= IW'(NUM_REQ - 1);
            tmo_cnt  <= '0;
            gap_cnt  <= '0;
            grant    <= '0;
            data_out <= '0;
            tx_start <= 1'b0;
            ack      <= '0;
            err      <= '0;
            busy     <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            ack      <= '0;
            err      <= '0;
            unique case (state)
                IDLE: begin
                    if (win_vld && !bus.Tx_busy) begin
                        grant    <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win;
                        data_out <= bus.Req_Data[int'(win)*DATA_W +: DATA_W];
                        tx_start <= 1'b1;
                        ptr      <= win;
                        busy     <= 1'b1;
                        state    <= START;
                    end
                end
                START: begin
                    tmo_cnt <= TW'(START_TIMEOUT - 1);
                    state   <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (bus.Tx_busy) begin
                        state <= WAIT_DONE;
                    end else if (tmo_cnt == '0) begin
                        err     <= grant;
                        grant   <= '0;
                        gap_cnt <= GW'(GAP_CYCLES - 1);
                        state   <= GAP;
                    end else begin
                        tmo_cnt <= tmo_cnt - TW'(1);
                    end
                end
                WAIT_DONE: begin
                    if (!bus.Tx_busy) begin
                        ack     <= grant;
                        grant   <= '0;
                        gap_cnt <= GW'(GAP_CYCLES - 1);
                        state   <= GAP;
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - GW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.Grant    = grant;
    assign bus.Data_Out = data_out;
    assign bus.Tx_start = tx_start;
    assign bus.Ack      = ack;
    assign bus.Err      = err;
    assign bus.Busy     = busy;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios followed by random frames,
// with expected winners taken from a round-robin pointer model kept in the bench.
module tb_uart_tx_arbiter;
    localparam int NUM_REQ       = 4;
    localparam int DATA_W        = 32;
    localparam int START_TIMEOUT = 16;
    localparam int GAP_CYCLES    = 2;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   exp_ptr;
    logic [DATA_W-1:0] words [NUM_REQ];

    uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ(NUM_REQ),
        .DATA_W(DATA_W),
        .START_TIMEOUT(START_TIMEOUT),
        .GAP_CYCLES(GAP_CYCLES)
    ) dut (
        .Clock_In(clk),
        .Reset(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Round-robin rule: first set request strictly after the pointer, wrapping.
    function automatic int pick(input int p, input logic [NUM_REQ-1:0] r);
        for (int k = 1; k <= NUM_REQ; k++)
            if (r[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
        return -1;
    endfunction

    task automatic drive_data();
        for (int i = 0; i < NUM_REQ; i++) bus.Req_Data[i*DATA_W +: DATA_W] = words[i];
    endtask

    task automatic new_words();
        for (int i = 0; i < NUM_REQ; i++) words[i] = $urandom;
        drive_data();
    endtask

    task automatic tail(input logic [DATA_W-1:0] dexp);
        for (int g = 1; g < GAP_CYCLES; g++) begin
            tick();
            chk("gap_busy", 64'(bus.Busy), 64'(1));
            chk("gap_pulse_clear", 64'(bus.Ack | bus.Err), 64'(0));
            chk("gap_grant", 64'(bus.Grant), 64'(0));
        end
        tick();
        chk("idle_busy", 64'(bus.Busy), 64'(0));
        chk("idle_grant", 64'(bus.Grant), 64'(0));
        chk("data_hold", 64'(bus.Data_Out), 64'(dexp));
    endtask

    // d < 0 means Tx_busy never rises (start timeout).
    task automatic do_frame(input logic [NUM_REQ-1:0] req, input int pre_busy, input int d,
                            input int blen, input bit drop, input bit scramble);
        int w;
        logic [DATA_W-1:0] dexp;
        logic [NUM_REQ-1:0] oh;
        bus.Req = req;
        drive_data();
        bus.Tx_busy = (pre_busy > 0);
        for (int i = 0; i < pre_busy; i++) begin
            tick();
            chk("no_grant_while_busy", 64'(bus.Grant), 64'(0));
            chk("no_start_while_busy", 64'(bus.Tx_start), 64'(0));
        end
        w    = pick(exp_ptr, req);
        oh   = NUM_REQ'(1) << w;
        dexp = words[w];
        bus.Tx_busy = 1'b0;
        tick();
        chk("grant", 64'(bus.Grant), 64'(oh));
        chk("data_out", 64'(bus.Data_Out), 64'(dexp));
        chk("tx_start", 64'(bus.Tx_start), 64'(1));
        chk("busy", 64'(bus.Busy), 64'(1));
        exp_ptr = w;
        if (scramble) new_words();
        tick();
        chk("tx_start_one_cycle", 64'(bus.Tx_start), 64'(0));
        if (d < 0) begin
            for (int i = 1; i < START_TIMEOUT; i++) begin
                tick();
                chk("no_early_err", 64'(bus.Err), 64'(0));
            end
            tick();
            chk("err_pulse", 64'(bus.Err), 64'(oh));
            chk("err_no_ack", 64'(bus.Ack), 64'(0));
            chk("err_grant_clear", 64'(bus.Grant), 64'(0));
        end else begin
            for (int i = 0; i < d; i++) begin
                tick();
                chk("wait_busy_no_err", 64'(bus.Err), 64'(0));
            end
            bus.Tx_busy = 1'b1;
            tick();
            chk("wait_done_grant", 64'(bus.Grant), 64'(oh));
            if (drop) bus.Req = req & ~oh;
            if (scramble) new_words();
            for (int i = 1; i < blen; i++) begin
                tick();
                chk("no_early_ack", 64'(bus.Ack | bus.Err), 64'(0));
            end
            bus.Tx_busy = 1'b0;
            tick();
            chk("ack_pulse", 64'(bus.Ack), 64'(oh));
            chk("ack_no_err", 64'(bus.Err), 64'(0));
            chk("ack_grant_clear", 64'(bus.Grant), 64'(0));
        end
        tail(dexp);
        bus.Req = '0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        tick();
        tick();
        chk("rst_outputs", 64'({bus.Grant, bus.Tx_start, bus.Ack, bus.Err, bus.Busy}), 64'(0));
        chk("rst_data", 64'(bus.Data_Out), 64'(0));
        rst_n = 1'b1;
        exp_ptr = NUM_REQ - 1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        exp_ptr  = NUM_REQ - 1;
        rst_n    = 1'b1;
        bus.Req  = '0;
        bus.Tx_busy = 1'b0;
        bus.Req_Data = '0;
        for (int i = 0; i < NUM_REQ; i++) words[i] = 32'h1111_0000 * (i + 1);
        #3 rst_n = 1'b0;
        tick();
        apply_reset();

        // Single requester, long frame
        words[0] = 32'hA5A5_1234;
        do_frame(4'b0001, 0, 2, 100, 1'b0, 1'b0);

        // Fairness from a fresh pointer: 0,1,2,3,0
        apply_reset();
        for (int f = 0; f < 5; f++) begin
            new_words();
            do_frame(4'b1111, 0, f, 3, 1'b0, f == 2);
        end

        // Start timeout, then arbitration resumes after the timed-out requester
        new_words();
        do_frame(4'b0100, 0, -1, 0, 1'b0, 1'b0);
        do_frame(4'b1111, 0, 1, 2, 1'b0, 1'b0);

        // Transmitter busy before arbitration
        do_frame(4'b0010, 4, 0, 5, 1'b0, 1'b0);

        // Tx_busy rises on the last cycle before timeout
        do_frame(4'b0001, 0, START_TIMEOUT - 1, 2, 1'b0, 1'b0);

        // Request dropped mid-frame, data changed after grant
        do_frame(4'b0010, 0, 0, 6, 1'b1, 1'b1);

        // Asynchronous reset during WAIT_DONE
        bus.Req = 4'b0100;
        tick();
        chk("pre_reset_grant", 64'(bus.Grant), 64'(4'b0100));
        tick();
        bus.Tx_busy = 1'b1;
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_outputs", 64'({bus.Grant, bus.Tx_start, bus.Ack, bus.Err, bus.Busy}), 64'(0));
        chk("async_rst_data", 64'(bus.Data_Out), 64'(0));
        tick();
        bus.Tx_busy = 1'b0;
        tick();
        chk("no_ack_after_abort", 64'(bus.Ack | bus.Err), 64'(0));
        rst_n = 1'b1;
        exp_ptr = NUM_REQ - 1;
        new_words();
        do_frame(4'b1001, 0, 0, 3, 1'b0, 1'b0);

        // Randomized frames against the pointer model
        for (int n = 0; n < 40; n++) begin
            logic [NUM_REQ-1:0] r;
            int dd;
            r  = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
            dd = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, START_TIMEOUT - 1));
            new_words();
            do_frame(r, int'($urandom_range(0, 2)), dd, int'($urandom_range(1, 12)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin scheduler that shares one UART transmitter path (baud generator plus transmitter) among NUM_REQ requesters.
- Arbitrates pending requests and latches the winner's 32-bit word onto the transmitter data input.
- Pulses the transmitter start strobe, tracks the frame through the transmitter busy flag, then acknowledges or flags an error to the winner.
- Sits between client logic and the transmitter top; runs entirely on the system clock, never on the baud clock.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- DATA_W, 32: width of each requester's data word and of Data_Out.
- START_TIMEOUT, 16: max Clock_In cycles in WAIT_BUSY for Tx_busy to rise before the frame is declared failed.
- GAP_CYCLES, 2: idle Clock_In cycles enforced between frames (≥1).

Ports:
- Clock_In  input  1  system clock; all logic on rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Req  input  NUM_REQ  level request per requester; held until Ack or Err.
- Req_Data  input  NUM_REQ*DATA_W  requester i's data in bits [i*DATA_W +: DATA_W].
- Tx_busy  input  1  high while the transmitter is sending a frame.
- Grant  output  NUM_REQ  one-hot; current owner of the transmitter.
- Data_Out  output  DATA_W  word driven to the transmitter Data_In.
- Tx_start  output  1  one-cycle start strobe to the transmitter.
- Ack  output  NUM_REQ  one-cycle pulse, frame completed for requester i.
- Err  output  NUM_REQ  one-cycle pulse, start timeout for requester i.
- Busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (Reset=0, async):
  - State enters IDLE.
  - Grant, Data_Out, Tx_start, Ack, Err and Busy all go to 0.
  - Round-robin pointer goes to NUM_REQ-1, so requester 0 has highest priority on the first arbitration.
  - Timeout and gap counters clear.
- Reset asserted mid-frame aborts immediately; no Ack or Err is issued for the aborted frame.
- All outputs are registered.
- States: IDLE, START, WAIT_BUSY, WAIT_DONE, GAP.
- IDLE:
  - If any Req bit is set and Tx_busy=0: winner = first set Req bit searching upward from pointer+1, wrapping modulo NUM_REQ.
  - On the next edge: Grant=onehot(winner), Data_Out=Req_Data[winner], Tx_start=1, pointer=winner, state goes to START.
  - If Tx_busy=1, stay in IDLE and do not arbitrate, even if Req is pending.
- START: lasts exactly 1 cycle with Tx_start=1. Next state is WAIT_BUSY with Tx_start=0 and the timeout counter cleared.
- WAIT_BUSY:
  - If Tx_busy=1, go to WAIT_DONE.
  - Otherwise increment the counter. When it reaches START_TIMEOUT: pulse Err[winner] for one cycle, clear Grant, go to GAP.
- WAIT_DONE:
  - Wait for Tx_busy=0; no timeout in this state.
  - On the falling edge: pulse Ack[winner] for one cycle, clear Grant, go to GAP.
- GAP: hold GAP_CYCLES cycles with Grant=0, then go to IDLE.
- Data_Out holds its last value until the next grant; it is never cleared except by reset.
- Latency: Req seen in IDLE at cycle 0 gives Grant, Data_Out and Tx_start valid at cycle 1.
- Ack/Err fire on the edge after the terminating condition is sampled.
- Minimum spacing between Tx_start pulses is 3 + GAP_CYCLES cycles plus the frame time.
- Req deasserted mid-transfer is ignored: the frame completes and Ack/Err still pulses. A Req_Data change after grant has no effect.
- A winner's Req still high at the next arbitration competes normally; the round-robin pointer prevents starvation.
- At most one bit of Grant, Ack or Err is set at any time; Ack and Err are never set in the same cycle.

Test Plan:
- Single requester: Req=4'b0001, Req_Data[31:0]=32'hA5A5_1234.
  - Cycle 1: Grant=0001, Data_Out=A5A5_1234, one-cycle Tx_start.
  - Tx_busy driven high for 100 cycles, then low: Ack[0] pulses once, then GAP_CYCLES idle cycles, then Busy=0.
- Fairness: Req=4'b1111 held, each frame acknowledged.
  - Grant order 0001, 0010, 0100, 1000, 0001.
  - Data_Out matches each requester's slice.
- Timeout: Req=4'b0100, Tx_busy held 0.
  - Err[2] pulses exactly START_TIMEOUT cycles after WAIT_BUSY is entered.
  - Ack stays 0, Grant clears, and the next arbitration starts from requester 3.
- Busy-before-arbitration: Tx_busy=1 while idle with Req=4'b0010.
  - No Grant or Tx_start while Tx_busy=1.
  - Grant=0010 one cycle after Tx_busy falls.
- Req drop mid-frame: Req[1] dropped during WAIT_DONE; Ack[1] still pulses on the Tx_busy fall.
- Async reset: Reset=0 pulsed mid-WAIT_DONE.
  - All outputs go to 0 immediately, with no Ack.
  - After release with Req=4'b1001, requester 0 is granted first.
